// File: rtl/fifo_rd_packer.sv
// Read-side drain engine: pulls narrow words from a standard-mode FIFO read port and packs
// RATIO of them (first word read in lane 0) into wide words behind a 2-entry output queue.
module fifo_rd_packer #(
   parameter  int IN_WIDTH  = 32,
   parameter  int OUT_WIDTH = 64,
   localparam int RATIO     = OUT_WIDTH / IN_WIDTH,
   localparam int LANE_W    = (RATIO > 1) ? $clog2(RATIO) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fifo_empty,
   output logic                 fifo_rd_en,
   input  logic [IN_WIDTH-1:0]  fifo_dout,
   input  logic                 fifo_valid,
   input  logic                 flush,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [OUT_WIDTH-1:0] m_data,
   output logic [RATIO-1:0]     m_keep,
   output logic                 busy,
   output logic                 err_missing
);

   logic [LANE_W-1:0]    lane_r;
   logic [OUT_WIDTH-1:0] pack_r;
   logic [RATIO-1:0]     keep_r;
   logic                 rd_pend_r;
   logic                 flush_pend_r;
   logic                 err_r;
   logic [1:0]           out_count_r;
   logic [OUT_WIDTH-1:0] q0_data_r;
   logic [OUT_WIDTH-1:0] q1_data_r;
   logic [RATIO-1:0]     q0_keep_r;
   logic [RATIO-1:0]     q1_keep_r;

   logic                 last_lane_s;
   logic [1:0]           proj_s;
   logic                 cap_s;
   logic                 full_s;
   logic                 pop_s;
   logic                 flush_go_s;
   logic                 flush_push_s;
   logic                 push_s;
   logic [OUT_WIDTH-1:0] pack_nx_s;
   logic [RATIO-1:0]     keep_nx_s;
   logic [OUT_WIDTH-1:0] push_data_s;
   logic [RATIO-1:0]     push_keep_s;

   // Occupancy the queue would reach if the in-flight read completes a word; capping it
   // at 2 is what keeps the queue from ever overflowing.
   assign last_lane_s  = (lane_r == LANE_W'(RATIO - 1));
   assign proj_s       = out_count_r + {1'b0, rd_pend_r & last_lane_s};
   assign fifo_rd_en   = !rst && !fifo_empty && !flush_pend_r && (proj_s < 2'd2);

   assign cap_s        = rd_pend_r && fifo_valid;
   assign full_s       = cap_s && last_lane_s;
   assign pop_s        = (out_count_r != 2'd0) && m_ready;
   assign flush_go_s   = flush_pend_r && !rd_pend_r && ((out_count_r != 2'd2) || pop_s);
   assign flush_push_s = flush_go_s && (lane_r != '0);
   assign push_s       = full_s || flush_push_s;

   // Pack register with the incoming narrow word merged into the current lane.
   always_comb begin
      pack_nx_s = pack_r;
      keep_nx_s = keep_r;
      for (int i = 0; i < RATIO; i++) begin
         pack_nx_s[i*IN_WIDTH +: IN_WIDTH] = (lane_r == LANE_W'(i)) ? fifo_dout
                                                                     : pack_r[i*IN_WIDTH +: IN_WIDTH];
         keep_nx_s[i] = keep_r[i] | (lane_r == LANE_W'(i));
      end
   end

   // A flush push can only happen with no read in flight, so the two sources never collide.
   assign push_data_s = full_s ? pack_nx_s : pack_r;
   assign push_keep_s = full_s ? keep_nx_s : keep_r;

   // Lane tracking, packing, read-pending, flush and error state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lane_r       <= '0;
         pack_r       <= '0;
         keep_r       <= '0;
         rd_pend_r    <= 1'b0;
         flush_pend_r <= 1'b0;
         err_r        <= 1'b0;
      end else begin
         rd_pend_r <= fifo_rd_en;
         if (rd_pend_r && !fifo_valid) begin
            err_r <= 1'b1;
         end
         if (flush_go_s) begin
            flush_pend_r <= 1'b0;
         end else if (flush) begin
            flush_pend_r <= 1'b1;
         end
         if (full_s || flush_go_s) begin
            lane_r <= '0;
            pack_r <= '0;
            keep_r <= '0;
         end else if (cap_s) begin
            lane_r <= lane_r + LANE_W'(1);
            pack_r <= pack_nx_s;
            keep_r <= keep_nx_s;
         end
      end
   end

   // Two-entry output queue; entry 0 is the head and drives the stream outputs directly.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_count_r <= 2'd0;
         q0_data_r   <= '0;
         q1_data_r   <= '0;
         q0_keep_r   <= '0;
         q1_keep_r   <= '0;
      end else begin
         case ({push_s, pop_s})
            2'b10: begin
               if (out_count_r == 2'd0) begin
                  q0_data_r <= push_data_s;
                  q0_keep_r <= push_keep_s;
               end else begin
                  q1_data_r <= push_data_s;
                  q1_keep_r <= push_keep_s;
               end
               out_count_r <= out_count_r + 2'd1;
            end
            2'b01: begin
               q0_data_r   <= q1_data_r;
               q0_keep_r   <= q1_keep_r;
               q1_data_r   <= '0;
               q1_keep_r   <= '0;
               out_count_r <= out_count_r - 2'd1;
            end
            2'b11: begin
               if (out_count_r == 2'd1) begin
                  q0_data_r <= push_data_s;
                  q0_keep_r <= push_keep_s;
               end else begin
                  q0_data_r <= q1_data_r;
                  q0_keep_r <= q1_keep_r;
                  q1_data_r <= push_data_s;
                  q1_keep_r <= push_keep_s;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign m_valid     = (out_count_r != 2'd0);
   assign m_data      = q0_data_r;
   assign m_keep      = q0_keep_r;
   assign busy        = (lane_r != '0) || rd_pend_r || flush_pend_r || (out_count_r != 2'd0);
   assign err_missing = err_r;

endmodule
